// File: rtl/hello_scroll_ctrl.sv
// HELLO rotation driver: timed auto-scroll or debounced single-step of the
// rotation index, with registered per-digit character codes for HEX5..HEX0.
module hello_scroll_ctrl #(
  parameter int unsigned TICK_DIV        = 25000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       run,
  input  logic       dir,
  input  logic       step_n,
  output logic [2:0] shift,
  output logic [2:0] h0,
  output logic [2:0] h1,
  output logic [2:0] h2,
  output logic [2:0] h3,
  output logic [2:0] h4,
  output logic [2:0] h5,
  output logic       step_tick
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {PAUSE = 1'b0, RUN = 1'b1} state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [DW-1:0] db_cnt;
  logic          key_s1, key_s2, key_db, key_db_q, armed;
  logic [1:0]    sync_ok;
  logic          press_pulse;
  logic          adv;
  logic [2:0]    shift_n;
  logic [3:0]    pos;
  logic [2:0]    h_n [6];

  // Message ring {blank, H, E, L, L, O}
  function automatic logic [2:0] ring_code(input logic [3:0] p);
    case (p)
      4'd0:       ring_code = 3'b100;
      4'd1:       ring_code = 3'b000;
      4'd2:       ring_code = 3'b001;
      4'd3, 4'd4: ring_code = 3'b010;
      default:    ring_code = 3'b011;
    endcase
  endfunction

  // Key synchronizer, debouncer, and release-before-press arming
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      key_s1   <= 1'b1;
      key_s2   <= 1'b1;
      sync_ok  <= 2'b00;
      key_db   <= 1'b1;
      key_db_q <= 1'b1;
      db_cnt   <= '0;
      armed    <= 1'b0;
    end else begin
      key_s1   <= step_n;
      key_s2   <= key_s1;
      sync_ok  <= {sync_ok[0], 1'b1};
      key_db_q <= key_db;
      if (key_s2 == key_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        key_db <= key_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
      // A key held through reset must be seen released before it can press
      if (sync_ok[1] && key_s2 && key_db) armed <= 1'b1;
    end
  end

  assign press_pulse = armed & key_db_q & ~key_db;

  // Next-state, prescaler, advance and character decode
  always_comb begin
    state_n = run ? RUN : PAUSE;
    presc_n = '0;
    adv     = 1'b0;
    shift_n = shift;
    pos     = '0;
    for (int i = 0; i < 6; i++) h_n[i] = 3'b100;

    if (state == RUN) begin
      if (presc == TICK_LAST) begin
        adv = 1'b1;
      end else if (run) begin
        presc_n = presc + PW'(1);
      end
    end else begin
      adv = press_pulse;
    end

    if (adv) begin
      if (dir) shift_n = (shift == 3'd0) ? 3'd5 : shift - 3'd1;
      else     shift_n = (shift == 3'd5) ? 3'd0 : shift + 3'd1;
    end

    for (int i = 0; i < 6; i++) begin
      pos = 4'(5 - i) + {1'b0, shift_n};
      if (pos >= 4'd6) pos = pos - 4'd6;
      h_n[i] = ring_code(pos);
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state     <= PAUSE;
      presc     <= '0;
      shift     <= 3'd0;
      step_tick <= 1'b0;
      h5        <= 3'b100;
      h4        <= 3'b000;
      h3        <= 3'b001;
      h2        <= 3'b010;
      h1        <= 3'b010;
      h0        <= 3'b011;
    end else begin
      state     <= state_n;
      presc     <= presc_n;
      shift     <= shift_n;
      step_tick <= adv;
      h0        <= h_n[0];
      h1        <= h_n[1];
      h2        <= h_n[2];
      h3        <= h_n[3];
      h4        <= h_n[4];
      h5        <= h_n[5];
    end
  end

endmodule
